// File: rtl/fetch_unit_pkg.sv
// Shared widths and state encoding for the instruction fetch unit.
package Definitions;

    localparam int unsigned PC_WIDTH        = 10;
    localparam int unsigned LUT_DEPTH       = 16;
    localparam int unsigned LUT_INDEX_WIDTH = $clog2(LUT_DEPTH);
    localparam int unsigned LUT_DATA_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Branch target table: combinational read, synchronous half-entry writes, synchronous clear.
module branch_lut
    import Definitions::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic                       load_hi,
    input  logic [LUT_INDEX_WIDTH-1:0] wr_index,
    input  logic [LUT_DATA_WIDTH-1:0]  wr_data,
    input  logic [LUT_INDEX_WIDTH-1:0] rd_index,
    output logic [PC_WIDTH-1:0]        rd_data
);

    logic [PC_WIDTH-1:0] entries [LUT_DEPTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            entries <= '{default: '0};
        end else if (wr_en) begin
            // Only the addressed half changes; upper data bits are dropped on a high write.
            if (load_hi)
                entries[wr_index][PC_WIDTH-1:LUT_DATA_WIDTH] <= wr_data[PC_WIDTH-LUT_DATA_WIDTH-1:0];
            else
                entries[wr_index][LUT_DATA_WIDTH-1:0] <= wr_data;
        end
    end

    assign rd_data = entries[rd_index];

endmodule

// File: rtl/fetch_unit.sv
// Program counter sequencer with a 16-entry branch target table.
// Optional taken-branch counter enabled by `define FETCH_BRANCH_COUNT_EN.
module fetch_unit
    import Definitions::*;
(
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       Start,
    input  logic                       PC_Jmp_Flag,
    input  logic                       PC_Beq_Flag,
    input  logic                       LUT_Read_En,
    input  logic                       LUT_Write_En,
    input  logic                       LUT_Load_Hi,
    input  logic [LUT_INDEX_WIDTH-1:0] LUT_Index,
    input  logic [LUT_DATA_WIDTH-1:0]  LUT_Data,
    input  logic                       Ack,
    output logic [PC_WIDTH-1:0]        PC,
    output logic                       Fetch_Valid,
    output logic                       Done
`ifdef FETCH_BRANCH_COUNT_EN
    ,
    output logic [15:0]                Branch_Count
`endif
);

    fetch_state_t        state, state_next;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] target;
    logic                branch_taken;
    logic                enter_run;

    // Branches resolve regardless of the lookup-enable strobe, so it carries no function here.
    logic unused_read_en;
    assign unused_read_en = LUT_Read_En;

    branch_lut u_branch_lut (
        .clk      (Clk),
        .reset_n  (Reset_n),
        .wr_en    (LUT_Write_En),
        .load_hi  (LUT_Load_Hi),
        .wr_index (LUT_Index),
        .wr_data  (LUT_Data),
        .rd_index (LUT_Index),
        .rd_data  (target)
    );

    always_comb begin
        state_next   = state;
        pc_next      = PC;
        branch_taken = 1'b0;
        enter_run    = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (Start) begin
                    state_next = RUN;
                    pc_next    = '0;
                    enter_run  = 1'b1;
                end
            end
            RUN: begin
                if (Ack) begin
                    state_next = HALT;
                end else if (PC_Jmp_Flag || PC_Beq_Flag) begin
                    pc_next      = target;
                    branch_taken = 1'b1;
                end else begin
                    pc_next = PC + PC_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
            PC    <= '0;
        end else begin
            state <= state_next;
            PC    <= pc_next;
        end
    end

    assign Fetch_Valid = (state == RUN);
    assign Done        = (state == HALT);

`ifdef FETCH_BRANCH_COUNT_EN
    always_ff @(posedge Clk) begin
        if (!Reset_n || enter_run)
            Branch_Count <= '0;
        else if (branch_taken && (Branch_Count != '1))
            Branch_Count <= Branch_Count + 16'd1;
    end
`else
    logic unused_branch;
    assign unused_branch = branch_taken ^ enter_run;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected outputs, a monitor checks them.
module tb_fetch_unit;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Start, PC_Jmp_Flag, PC_Beq_Flag, LUT_Read_En;
    logic       LUT_Write_En, LUT_Load_Hi, Ack;
    logic [3:0] LUT_Index;
    logic [7:0] LUT_Data;
    logic [9:0] PC;
    logic       Fetch_Valid, Done;
`ifdef FETCH_BRANCH_COUNT_EN
    logic [15:0] Branch_Count;
`endif

    fetch_unit dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .PC_Jmp_Flag  (PC_Jmp_Flag),
        .PC_Beq_Flag  (PC_Beq_Flag),
        .LUT_Read_En  (LUT_Read_En),
        .LUT_Write_En (LUT_Write_En),
        .LUT_Load_Hi  (LUT_Load_Hi),
        .LUT_Index    (LUT_Index),
        .LUT_Data     (LUT_Data),
        .Ack          (Ack),
        .PC           (PC),
        .Fetch_Valid  (Fetch_Valid),
        .Done         (Done)
`ifdef FETCH_BRANCH_COUNT_EN
        ,
        .Branch_Count (Branch_Count)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int unsigned cyc;
        string       name;
        logic [9:0]  pc;
        logic        fv;
        logic        done;
        bit          chk_bc;
        logic [15:0] bc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc   = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares every expectation tagged for the cycle just completed.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                if (e.cyc != cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL %s: expectation for cycle %0d missed, now %0d", e.name, e.cyc, cyc);
                end else begin
                    chk({e.name, ".pc"}, {6'd0, PC}, {6'd0, e.pc});
                    chk({e.name, ".valid"}, {15'd0, Fetch_Valid}, {15'd0, e.fv});
                    chk({e.name, ".done"}, {15'd0, Done}, {15'd0, e.done});
`ifdef FETCH_BRANCH_COUNT_EN
                    if (e.chk_bc) chk({e.name, ".bcount"}, Branch_Count, e.bc);
`endif
                end
            end
        end
    end

    task automatic drv(input logic st, input logic jmp, input logic beq, input logic rd,
                       input logic we, input logic hi, input logic [3:0] idx,
                       input logic [7:0] data, input logic ack);
        Start        = st;
        PC_Jmp_Flag  = jmp;
        PC_Beq_Flag  = beq;
        LUT_Read_En  = rd;
        LUT_Write_En = we;
        LUT_Load_Hi  = hi;
        LUT_Index    = idx;
        LUT_Data     = data;
        Ack          = ack;
    endtask

    task automatic tick(input string name, input logic [9:0] pc, input logic fv, input logic done,
                        input bit chk_bc = 1'b0, input logic [15:0] bc = 16'd0);
        exp_t e;
        e.cyc    = cyc + 1;
        e.name   = name;
        e.pc     = pc;
        e.fv     = fv;
        e.done   = done;
        e.chk_bc = chk_bc;
        e.bc     = bc;
        exp_q.push_back(e);
        @(negedge Clk);
    endtask

    initial begin
        Reset_n = 1'b0;
        drv(1, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0);
        @(negedge Clk);
        tick("reset_a", 10'h000, 0, 0);
        tick("reset_b", 10'h000, 0, 0);

        Reset_n = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0);
        tick("idle", 10'h000, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0);
        tick("start", 10'h000, 1, 0);
        drv(0, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0);
        tick("seq1", 10'h001, 1, 0);
        tick("seq2", 10'h002, 1, 0);
        tick("seq3", 10'h003, 1, 0);

        drv(0, 0, 0, 0, 1, 0, 4'd5, 8'h34, 0); tick("wr5_lo", 10'h004, 1, 0);
        drv(0, 0, 0, 0, 1, 1, 4'd5, 8'h02, 0); tick("wr5_hi", 10'h005, 1, 0);
        drv(0, 1, 0, 1, 0, 0, 4'd5, 8'h00, 0); tick("jmp5", 10'h234, 1, 0);
        drv(0, 0, 0, 0, 1, 0, 4'd2, 8'h05, 0); tick("wr2_lo", 10'h235, 1, 0);
        drv(0, 0, 0, 0, 1, 1, 4'd2, 8'h00, 0); tick("wr2_hi", 10'h236, 1, 0);
        drv(0, 0, 0, 0, 1, 0, 4'd3, 8'h10, 0); tick("wr3_lo", 10'h237, 1, 0);
        drv(0, 0, 0, 0, 1, 1, 4'd3, 8'h00, 0); tick("wr3_hi", 10'h238, 1, 0);

        drv(0, 1, 1, 0, 0, 0, 4'd3, 8'h00, 0); tick("jmp_beq3_nord", 10'h010, 1, 0);
        drv(0, 0, 1, 1, 0, 0, 4'd3, 8'h00, 0); tick("beq3", 10'h010, 1, 0);
        drv(0, 0, 0, 0, 0, 0, 4'd3, 8'h00, 0); tick("noflag", 10'h011, 1, 0);

        drv(0, 1, 0, 1, 1, 0, 4'd2, 8'h99, 0); tick("collide", 10'h005, 1, 0);
        drv(0, 1, 0, 1, 0, 0, 4'd2, 8'h00, 0); tick("jmp2_new", 10'h099, 1, 0);
        drv(0, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0); tick("after_new", 10'h09A, 1, 0);

        drv(0, 0, 0, 0, 1, 0, 4'd7, 8'hFF, 0); tick("wr7_lo", 10'h09B, 1, 0);
        drv(0, 0, 0, 0, 1, 1, 4'd7, 8'hFF, 0); tick("wr7_hi", 10'h09C, 1, 0);
        drv(0, 1, 0, 1, 0, 0, 4'd7, 8'h00, 0); tick("jmp7", 10'h3FF, 1, 0);
        drv(0, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0); tick("wrap", 10'h000, 1, 0);
        for (int unsigned i = 1; i <= 7; i++) tick("count", 10'(i), 1, 0);

        drv(0, 1, 0, 1, 0, 0, 4'd5, 8'h00, 1); tick("halt", 10'h007, 0, 1);
        drv(0, 1, 0, 0, 0, 0, 4'd5, 8'h00, 0); tick("halt_hold", 10'h007, 0, 1);
        drv(1, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0); tick("restart", 10'h000, 1, 0, 1, 16'd0);
        drv(0, 1, 0, 1, 0, 0, 4'd5, 8'h00, 0); tick("lut_kept", 10'h234, 1, 0, 1, 16'd1);
        drv(1, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0); tick("start_in_run", 10'h235, 1, 0, 1, 16'd1);
        drv(0, 0, 1, 1, 0, 0, 4'd3, 8'h00, 0); tick("beq3_b", 10'h010, 1, 0, 1, 16'd2);
        drv(0, 1, 0, 1, 0, 0, 4'd2, 8'h00, 0); tick("jmp2_b", 10'h099, 1, 0, 1, 16'd3);

        Reset_n = 1'b0;
        drv(0, 1, 0, 1, 0, 0, 4'd5, 8'h00, 0); tick("rst_mid", 10'h000, 0, 0, 1, 16'd0);
        Reset_n = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0); tick("idle2", 10'h000, 0, 0, 1, 16'd0);
        drv(1, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0); tick("restart2", 10'h000, 1, 0, 1, 16'd0);
        drv(0, 1, 0, 1, 0, 0, 4'd5, 8'h00, 0); tick("lut_zero5", 10'h000, 1, 0, 1, 16'd1);
        drv(0, 0, 1, 1, 0, 0, 4'd7, 8'h00, 0); tick("lut_zero7", 10'h000, 1, 0, 1, 16'd2);
        drv(0, 0, 0, 0, 0, 0, 4'd0, 8'h00, 1); tick("halt2", 10'h000, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0);

        for (int unsigned i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge Clk);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
